// File: rtl/layer_out_collector.sv
// layer_out_collector
//   Receives a layer's output stream one signed element per beat. It collects
//   M-element vectors into a ping-pong buffer, so one bank fills while the
//   other drains. Each completed vector is sent downstream with its element
//   index and a last flag.
//
//   Optional feature: define LAYER_OUT_COLLECTOR_ARGMAX_EN to report the
//   draining vector's max value and the index of that max. When the macro is
//   undefined there is no compare logic, and m_argmax and m_max stay 0.
//
//   Ports
//     clk       clock, all logic on posedge
//     reset     synchronous, active-high
//     s_valid   upstream element valid
//     s_ready   collector can accept an element
//     data_in   signed T-bit element from the layer
//     m_valid   downstream element valid
//     m_ready   downstream accepts
//     data_out  element of the draining vector (0 when m_valid=0)
//     m_index   index of data_out within its vector (0 when m_valid=0)
//     m_last    high on element M-1 (0 when m_valid=0)
//     m_argmax  index of the max element of the draining vector (0 when m_valid=0)
//     m_max     value of the max element of the draining vector (0 when m_valid=0)
module layer_out_collector #(
  parameter int M = 8,
  parameter int T = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [T-1:0]  data_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [T-1:0]  data_out,
  output logic [$clog2(M)-1:0] m_index,
  output logic                 m_last,
  output logic [$clog2(M)-1:0] m_argmax,
  output logic signed [T-1:0]  m_max
);

  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);
  localparam logic [IW-1:0] ZERO_IDX = IW'(0);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  logic signed [T-1:0] bank_r [2][M];
  logic [1:0]          full_r;
  logic [1:0]          full_next_s;
  logic                wr_bank_r;
  logic                rd_bank_r;
  logic [IW-1:0]       wr_cnt_r;
  logic [IW-1:0]       rd_cnt_r;
  logic                wr_fire_s;
  logic                rd_fire_s;
  logic                wr_done_s;
  logic                rd_done_s;

  // Handshake decode: each side is gated by its bank's full flag and by reset.
  always_comb begin
    s_ready   = !reset && !full_r[wr_bank_r];
    m_valid   = !reset && full_r[rd_bank_r];
    wr_fire_s = s_valid && s_ready;
    rd_fire_s = m_valid && m_ready;
    wr_done_s = wr_fire_s && (wr_cnt_r == LAST_IDX);
    rd_done_s = rd_fire_s && (rd_cnt_r == LAST_IDX);
  end

  // Full-flag update. A fill and a drain can complete together; they always
  // target different banks, because the write bank is empty and the read bank is full.
  always_comb begin
    full_next_s = full_r;
    if (wr_done_s) begin
      full_next_s[wr_bank_r] = 1'b1;
    end else begin
      full_next_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (rd_done_s) begin
      full_next_s[rd_bank_r] = 1'b0;
    end else begin
      full_next_s[rd_bank_r] = full_next_s[rd_bank_r];
    end
  end

  // Control state: full flags, bank pointers and element counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= ZERO_IDX;
      rd_cnt_r  <= ZERO_IDX;
    end else begin
      full_r <= full_next_s;
      if (wr_fire_s) begin
        if (wr_done_s) begin
          wr_cnt_r  <= ZERO_IDX;
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_cnt_r <= wr_cnt_r + ONE_IDX;
        end
      end
      if (rd_fire_s) begin
        if (rd_done_s) begin
          rd_cnt_r  <= ZERO_IDX;
          rd_bank_r <= ~rd_bank_r;
        end else begin
          rd_cnt_r <= rd_cnt_r + ONE_IDX;
        end
      end
    end
  end

  // Element storage. It needs no reset, because the full flags guard every read.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      bank_r[wr_bank_r][wr_cnt_r] <= data_in;
    end
  end

  // Downstream element fields. They are forced to zero while nothing is valid.
  always_comb begin
    data_out = {T{1'b0}};
    m_index  = ZERO_IDX;
    m_last   = 1'b0;
    if (m_valid) begin
      data_out = bank_r[rd_bank_r][rd_cnt_r];
      m_index  = rd_cnt_r;
      m_last   = (rd_cnt_r == LAST_IDX);
    end else begin
      data_out = {T{1'b0}};
      m_index  = ZERO_IDX;
      m_last   = 1'b0;
    end
  end

`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
  logic signed [T-1:0] run_max_r;
  logic [IW-1:0]       run_idx_r;
  logic signed [T-1:0] cand_max_s;
  logic [IW-1:0]       cand_idx_s;
  logic signed [T-1:0] res_max_r [2];
  logic [IW-1:0]       res_idx_r [2];

  // Running max including the incoming element. Element 0 seeds the max.
  // Only a strictly greater value replaces it, so ties keep the lower index.
  always_comb begin
    cand_max_s = run_max_r;
    cand_idx_s = run_idx_r;
    if (wr_cnt_r == ZERO_IDX) begin
      cand_max_s = data_in;
      cand_idx_s = ZERO_IDX;
    end else if (data_in > run_max_r) begin
      cand_max_s = data_in;
      cand_idx_s = wr_cnt_r;
    end else begin
      cand_max_s = run_max_r;
      cand_idx_s = run_idx_r;
    end
  end

  // Track the running max. Latch the result into the bank that is filling, at the same time as its full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_max_r    <= {T{1'b0}};
      run_idx_r    <= ZERO_IDX;
      res_max_r[0] <= {T{1'b0}};
      res_max_r[1] <= {T{1'b0}};
      res_idx_r[0] <= ZERO_IDX;
      res_idx_r[1] <= ZERO_IDX;
    end else if (wr_fire_s) begin
      run_max_r <= cand_max_s;
      run_idx_r <= cand_idx_s;
      if (wr_done_s) begin
        res_max_r[wr_bank_r] <= cand_max_s;
        res_idx_r[wr_bank_r] <= cand_idx_s;
      end
    end
  end

  // Argmax report for the draining bank. It stays constant across the bank's M beats.
  always_comb begin
    m_argmax = ZERO_IDX;
    m_max    = {T{1'b0}};
    if (m_valid) begin
      m_argmax = res_idx_r[rd_bank_r];
      m_max    = res_max_r[rd_bank_r];
    end else begin
      m_argmax = ZERO_IDX;
      m_max    = {T{1'b0}};
    end
  end
`else
  // Argmax reporting is disabled, so these outputs are tied to zero.
  always_comb begin
    m_argmax = ZERO_IDX;
    m_max    = {T{1'b0}};
  end
`endif

endmodule

// File: tb/tb_layer_out_collector.sv
module tb_layer_out_collector;

  localparam int M = 8;
  localparam int T = 8;

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] data_in;
  logic              m_valid;
  logic              m_ready;
  logic signed [7:0] data_out;
  logic [2:0]        m_index;
  logic              m_last;
  logic [2:0]        m_argmax;
  logic signed [7:0] m_max;

  layer_out_collector #(.M(M), .T(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .m_index  (m_index),
    .m_last   (m_last),
    .m_argmax (m_argmax),
    .m_max    (m_max)
  );

  typedef struct {
    int d;
    int idx;
    int last;
    int amax;
    int mx;
  } beat_t;

  beat_t exp_q[$];
  int    part_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: when a vector completes, queue its M expected output beats.
  function automatic void model_accept(input int d);
    int mx;
    int am;
    part_q.push_back(d);
    if (part_q.size() == M) begin
      mx = part_q[0];
      foreach (part_q[i]) if (part_q[i] > mx) mx = part_q[i];
      am = -1;
      foreach (part_q[i]) if (am < 0 && part_q[i] == mx) am = i;
`ifndef LAYER_OUT_COLLECTOR_ARGMAX_EN
      am = 0;
      mx = 0;
`endif
      for (int i = 0; i < M; i++) begin
        beat_t b;
        b.d    = part_q[i];
        b.idx  = i;
        b.last = (i == M - 1) ? 1 : 0;
        b.amax = am;
        b.mx   = mx;
        exp_q.push_back(b);
      end
      part_q.delete();
    end
  endfunction

  // Monitor: pop and compare on every output handshake; check the stall hold and the zero fields when idle.
  initial begin
    bit hold;
    int h_d, h_i, h_l, h_a, h_m;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", int'(m_valid), 1);
          chk("hold_data", int'(data_out), h_d);
          chk("hold_index", int'(m_index), h_i);
          chk("hold_last", int'(m_last), h_l);
          chk("hold_argmax", int'(m_argmax), h_a);
          chk("hold_max", int'(m_max), h_m);
        end
        if (!m_valid) begin
          chk("idle_zero", int'({data_out, m_index, m_last, m_argmax, m_max}), 0);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got beat index %0d data %0d, required none", m_index, data_out);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("sb_data", int'(data_out), e.d);
            chk("sb_index", int'(m_index), e.idx);
            chk("sb_last", int'(m_last), e.last);
            chk("sb_argmax", int'(m_argmax), e.amax);
            chk("sb_max", int'(m_max), e.mx);
          end
        end
        hold = m_valid && !m_ready;
        h_d = int'(data_out);
        h_i = int'(m_index);
        h_l = int'(m_last);
        h_a = int'(m_argmax);
        h_m = int'(m_max);
      end
    end
  end

  task automatic step(input bit v, input int d, input bit rdy, output bit acc);
    @(negedge clk);
    s_valid = v;
    data_in = 8'(d);
    m_ready = rdy;
    #2;
    acc = v && s_ready;
    if (acc) model_accept(d);
  endtask

  task automatic send_vec(input int vals[8], input bit rdy);
    bit acc;
    for (int i = 0; i < M; i++) begin
      int tries;
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 100) begin
        step(1'b1, vals[i], rdy, acc);
        tries++;
      end
      chk("send_accept", int'(acc), 1);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 400) begin
      step(1'b0, 0, 1'b1, acc);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    part_q.delete();
    exp_q.delete();
    #2;
    chk("rst_sready", int'(s_ready), 0);
    chk("rst_mvalid", int'(m_valid), 0);
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("rst_mvalid_hold", int'(m_valid), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_rel_sready", int'(s_ready), 1);
    chk("rst_rel_mvalid", int'(m_valid), 0);
  endtask

  initial begin
    bit acc;
    int v1[8];
    int vt[8];
    int vn[8];
    int vr[8];
    v1 = '{3, 1, 4, 1, 5, 9, 2, 6};
    vt = '{7, 7, 0, 0, 0, 0, 0, 7};
    vn = '{-3, -1, -8, -2, -5, -6, -7, -4};
    vr = '{8, 7, 6, 5, 4, 3, 2, 1};
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = 8'sd0;

    // Test 1: a basic vector with the downstream always ready.
    do_reset();
    send_vec(v1, 1'b1);
    drain();

    // Test 2: both banks fill while stalled, then drain; s_ready returns after A's last beat.
    do_reset();
    for (int i = 0; i < 2 * M; i++) begin
      step(1'b1, $urandom_range(0, 255) - 128, 1'b0, acc);
      chk("t2_accept", int'(acc), 1);
    end
    step(1'b0, 0, 1'b0, acc);
    chk("t2_sready_full", int'(s_ready), 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 30 && !seen; n++) begin
        step(1'b0, 0, 1'b1, acc);
        if (m_valid && m_last) begin
          seen = 1'b1;
          chk("t2_sready_at_last", int'(s_ready), 0);
          step(1'b0, 0, 1'b1, acc);
          chk("t2_sready_after", int'(s_ready), 1);
        end
      end
      chk("t2_last_seen", int'(seen), 1);
    end
    drain();

    // Test 3: ties and negative values.
    send_vec(vt, 1'b1);
    drain();
    send_vec(vn, 1'b1);
    drain();

    // Test 6: the last drain beat of bank 0 and the fill of bank 1 complete on the same edge.
    do_reset();
    for (int i = 0; i < 2 * M; i++) begin
      step(1'b1, i * 5 - 40, 1'b1, acc);
      chk("t6_accept", int'(acc), 1);
    end
    step(1'b0, 0, 1'b1, acc);
    chk("t6_mvalid", int'(m_valid), 1);
    chk("t6_index", int'(m_index), 0);
    drain();

    // Test 5: reset with a partial vector pending and a full bank draining.
    do_reset();
    for (int i = 0; i < M; i++) step(1'b1, i + 20, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b1, i + 40, 1'b1, acc);
    do_reset();
    send_vec(vr, 1'b1);
    drain();

    // Test 4: random throttling on both sides for 100 vectors.
    do_reset();
    begin
      int sent;
      int cyc;
      sent = 0;
      cyc  = 0;
      while (sent < 100 * M && cyc < 20000) begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 255) - 128,
             1'($urandom_range(0, 1)), acc);
        if (acc) sent++;
        cyc++;
      end
      chk("t4_all_sent", sent, 100 * M);
    end
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
